// File: rtl/pc_fetch_stage_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_stage_if
//   Instruction-memory fetch bus between the fetch stage and instruction memory.
//   A request is held high, with a stable word-aligned address, until the
//   memory answers with a single-cycle ack that carries the read data.
//
//   Signals
//     imem_req    fetch request, held until imem_ack
//     imem_addr   32-bit word-aligned fetch address, stable while imem_req=1
//     imem_ack    memory returns imem_rdata this cycle
//     imem_rdata  32-bit fetched instruction word
//
//   Modports
//     master  fetch side (drives req/addr, receives ack/rdata)
//     slave   memory side (receives req/addr, drives ack/rdata)
// -----------------------------------------------------------------------------
interface pc_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_stage.sv
// -----------------------------------------------------------------------------
// pc_fetch_stage
//   Owns the architectural PC of the mini-MIPS core and the instruction-fetch
//   handshake. The word at pc is fetched over a req/ack bus and presented as
//   {pc, instr} to decode and to the combinational next-PC unit, which returns
//   next_pc. Decode stall and branch/jump flush are resolved here.
//
//   Parameters
//     RESET_PC  PC loaded on reset and used as the first fetch address
//     MAX_WAIT  cycles a request may stay un-acked before fetch_err (>= 1)
//
//   Ports
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     next_pc      next-PC unit result; valid while instr_valid=1 or flush=1
//     stall        decode cannot accept; hold pc/instr
//     flush        control redirect; drop current/in-flight word, load next_pc
//     imem         fetch bus (master side): imem_req, imem_addr, imem_ack,
//                  imem_rdata
//     pc           address of instr
//     instr        fetched instruction word
//     instr_valid  instr/pc valid for decode
//     fetch_err    sticky error, cleared only by reset
//     misalign     sticky misaligned-PC flag
//
//   Optional feature (compile-time macro FETCH_MISALIGN_CHECK_EN)
//     Defined:   any PC load whose low two bits are non-zero (and a misaligned
//                RESET_PC seen in the first idle cycle) issues no request,
//                sets misalign and fetch_err and parks in the error state with
//                the offending value kept in pc.
//     Undefined: pc keeps the full next_pc value, imem_addr simply masks the
//                low two bits and misalign stays 0.
// -----------------------------------------------------------------------------
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          MAX_WAIT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             next_pc,
    input  logic                    stall,
    input  logic                    flush,
    pc_fetch_stage_if.master        imem,
    output logic [31:0]             pc,
    output logic [31:0]             instr,
    output logic                    instr_valid,
    output logic                    fetch_err,
    output logic                    misalign
);

    // Wide enough to hold MAX_WAIT itself, although the counter never
    // advances past MAX_WAIT-1 before the timeout fires.
    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t          state_reg;
    logic [31:0]     pc_reg;
    logic [31:0]     pc_pend_reg;
    logic [31:0]     instr_reg;
    logic            instr_valid_reg;
    logic            fetch_err_reg;
    logic            misalign_reg;
    logic [WCW-1:0]  wait_cnt_reg;
    logic            drop_reg;

    // Misalignment of each value that can be loaded into pc. Without the
    // check these are constant 0, which removes every error branch below
    // that depends on them.
    logic bad_next;
    logic bad_pend;
    logic bad_cur;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign bad_next = (next_pc[1:0]     != 2'b00);
    assign bad_pend = (pc_pend_reg[1:0] != 2'b00);
    assign bad_cur  = (pc_reg[1:0]      != 2'b00);
`else
    assign bad_next = 1'b0;
    assign bad_pend = 1'b0;
    assign bad_cur  = 1'b0;
`endif

    logic timeout;
    assign timeout = (wait_cnt_reg == WAIT_LAST);

    // -------------------------------------------------------------------------
    // Fetch FSM. All outputs are registers or a direct decode of state_reg,
    // so an asynchronous reset removes the request immediately.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            pc_reg          <= RESET_PC;
            pc_pend_reg     <= 32'h0;
            instr_reg       <= 32'h0;
            instr_valid_reg <= 1'b0;
            fetch_err_reg   <= 1'b0;
            misalign_reg    <= 1'b0;
            wait_cnt_reg    <= '0;
            drop_reg        <= 1'b0;
        end else begin
            case (state_reg)
                // One idle cycle before each fresh request. A misaligned pc
                // can only arrive here from reset, since every other load is
                // screened at the moment it happens.
                ST_IDLE: begin
                    if (bad_cur) begin
                        misalign_reg  <= 1'b1;
                        fetch_err_reg <= 1'b1;
                        state_reg     <= ST_ERR;
                    end else begin
                        wait_cnt_reg <= '0;
                        state_reg    <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (imem.imem_ack) begin
                        drop_reg <= 1'b0;
                        if (flush) begin
                            // Flush beats a simultaneous ack: the returning
                            // word belongs to the abandoned path.
                            pc_reg <= next_pc;
                            if (bad_next) begin
                                misalign_reg  <= 1'b1;
                                fetch_err_reg <= 1'b1;
                                state_reg     <= ST_ERR;
                            end else begin
                                state_reg <= ST_IDLE;
                            end
                        end else if (drop_reg) begin
                            // The ack closes a request that was flushed
                            // earlier; restart from the redirect target.
                            pc_reg <= pc_pend_reg;
                            if (bad_pend) begin
                                misalign_reg  <= 1'b1;
                                fetch_err_reg <= 1'b1;
                                state_reg     <= ST_ERR;
                            end else begin
                                state_reg <= ST_IDLE;
                            end
                        end else begin
                            instr_reg       <= imem.imem_rdata;
                            instr_valid_reg <= 1'b1;
                            state_reg       <= ST_HOLD;
                        end
                    end else if (timeout) begin
                        fetch_err_reg <= 1'b1;
                        state_reg     <= ST_ERR;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WCW'(1);
                        // The bus protocol forbids withdrawing an open
                        // request, so remember the redirect and keep
                        // req/addr unchanged until the ack drains it.
                        if (flush) begin
                            drop_reg    <= 1'b1;
                            pc_pend_reg <= next_pc;
                        end
                    end
                end

                ST_HOLD: begin
                    if (flush) begin
                        instr_valid_reg <= 1'b0;
                        pc_reg          <= next_pc;
                        if (bad_next) begin
                            misalign_reg  <= 1'b1;
                            fetch_err_reg <= 1'b1;
                            state_reg     <= ST_ERR;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end else if (!stall) begin
                        // Sequential advance goes straight back to REQ so a
                        // non-stalled stream needs no idle cycle.
                        instr_valid_reg <= 1'b0;
                        pc_reg          <= next_pc;
                        wait_cnt_reg    <= '0;
                        if (bad_next) begin
                            misalign_reg  <= 1'b1;
                            fetch_err_reg <= 1'b1;
                            state_reg     <= ST_ERR;
                        end else begin
                            state_reg <= ST_REQ;
                        end
                    end
                end

                // Terminal until reset; everything is simply held.
                ST_ERR: begin
                    instr_valid_reg <= 1'b0;
                end

                default: begin
                    state_reg <= ST_ERR;
                end
            endcase
        end
    end

    assign imem.imem_req  = (state_reg == ST_REQ);
    assign imem.imem_addr = {pc_reg[31:2], 2'b00};

    assign pc          = pc_reg;
    assign instr       = instr_reg;
    assign instr_valid = instr_valid_reg;
    assign fetch_err   = fetch_err_reg;
    assign misalign    = misalign_reg;

endmodule

// File: tb/tb_pc_fetch_stage.sv
module tb_pc_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam int          MAX_WAIT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] next_pc;
    logic        stall;
    logic        flush;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fetch_err;
    logic        misalign;

    int checks   = 0;
    int failures = 0;

    // Reference model state: the PC the stage should be fetching and the word
    // decode should currently see.
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;

    pc_fetch_stage_if bus ();

    pc_fetch_stage #(
        .RESET_PC (RESET_PC),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .next_pc     (next_pc),
        .stall       (stall),
        .flush       (flush),
        .imem        (bus),
        .pc          (pc),
        .instr       (instr),
        .instr_valid (instr_valid),
        .fetch_err   (fetch_err),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    // At a falling edge where a new request should be open for exp_pc.
    task automatic expect_req(input string tag);
        check({tag, "_req"},   bus.imem_req, 1'b1);
        check({tag, "_addr"},  bus.imem_addr, exp_pc & 32'hFFFF_FFFC);
        check({tag, "_pc"},    pc, exp_pc);
        check({tag, "_valid"}, instr_valid, 1'b0);
        check({tag, "_err"},   fetch_err, 1'b0);
    endtask

    // Memory answers after lat un-acked cycles; the word shows up one cycle
    // after the ack.
    task automatic do_fetch(input int lat, input logic [31:0] data);
        for (int i = 0; i < lat; i++) begin
            step();
            check("wait_req",  bus.imem_req, 1'b1);
            check("wait_addr", bus.imem_addr, exp_pc & 32'hFFFF_FFFC);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        step();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        exp_instr = data;
        check("fetch_valid", instr_valid, 1'b1);
        check("fetch_instr", instr, data);
        check("fetch_pc",    pc, exp_pc);
        check("fetch_noreq", bus.imem_req, 1'b0);
    endtask

    // Stall for ns cycles (stray acks must be ignored), then advance to npc.
    task automatic hold_then_advance(input int ns, input logic [31:0] npc);
        stall = 1'b1;
        for (int i = 0; i < ns; i++) begin
            bus.imem_ack   = 1'($urandom_range(0, 1));
            bus.imem_rdata = $urandom;
            step();
            check("stall_valid", instr_valid, 1'b1);
            check("stall_instr", instr, exp_instr);
            check("stall_pc",    pc, exp_pc);
            check("stall_noreq", bus.imem_req, 1'b0);
        end
        bus.imem_ack = 1'b0;
        stall   = 1'b0;
        next_pc = npc;
        step();
        next_pc = $urandom;
        exp_pc  = npc;
        expect_req("advance");
    endtask

    // Flush while a request is open; the late ack must be swallowed.
    task automatic flush_in_req(input int pre, input int lat, input logic [31:0] npc);
        logic [31:0] old_pc;
        old_pc = exp_pc;
        for (int i = 0; i < pre; i++) begin
            step();
            check("pre_req", bus.imem_req, 1'b1);
        end
        flush   = 1'b1;
        next_pc = npc;
        step();
        flush   = 1'b0;
        next_pc = $urandom;
        check("fl_req_held",  bus.imem_req, 1'b1);
        check("fl_addr_held", bus.imem_addr, old_pc & 32'hFFFF_FFFC);
        check("fl_pc_held",   pc, old_pc);
        for (int i = 0; i < lat; i++) begin
            step();
            check("fl_wait_addr", bus.imem_addr, old_pc & 32'hFFFF_FFFC);
            check("fl_wait_valid", instr_valid, 1'b0);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = $urandom;
        step();
        bus.imem_ack = 1'b0;
        check("fl_drop_valid", instr_valid, 1'b0);
        check("fl_idle_req",   bus.imem_req, 1'b0);
        exp_pc = npc;
        step();
        expect_req("fl_restart");
    endtask

    task automatic flush_with_ack(input logic [31:0] npc);
        flush          = 1'b1;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = $urandom;
        next_pc        = npc;
        step();
        flush        = 1'b0;
        bus.imem_ack = 1'b0;
        next_pc      = $urandom;
        exp_pc       = npc;
        check("fa_valid", instr_valid, 1'b0);
        check("fa_idle",  bus.imem_req, 1'b0);
        check("fa_pc",    pc, npc);
        step();
        expect_req("fa_restart");
    endtask

    // Flush while decode holds a word; flush takes priority over stall.
    task automatic flush_in_hold(input logic [31:0] npc);
        flush   = 1'b1;
        stall   = 1'($urandom_range(0, 1));
        next_pc = npc;
        step();
        flush   = 1'b0;
        stall   = 1'b0;
        next_pc = $urandom;
        exp_pc  = npc;
        check("fh_valid", instr_valid, 1'b0);
        check("fh_idle",  bus.imem_req, 1'b0);
        check("fh_pc",    pc, npc);
        step();
        expect_req("fh_restart");
    endtask

    initial begin
        rst_n          = 1'b0;
        next_pc        = 32'h0;
        stall          = 1'b0;
        flush          = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        exp_pc         = RESET_PC;
        exp_instr      = 32'h0;

        // Reset state
        repeat (2) step();
        check("rst_pc",    pc, RESET_PC);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_req",   bus.imem_req, 1'b0);
        check("rst_err",   fetch_err, 1'b0);
        check("rst_mis",   misalign, 1'b0);

        // 1: first fetch, ack two cycles after the request
        rst_n = 1'b1;
        step();
        expect_req("t1");
        check("t1_addr_abs", bus.imem_addr, 32'h0040_0000);
        do_fetch(2, 32'h2008_0005);

        // 2: three stalled cycles then sequential advance
        hold_then_advance(3, 32'h0040_0004);
        check("t2_addr_abs", bus.imem_addr, 32'h0040_0004);
        do_fetch(1, $urandom);
        hold_then_advance(0, 32'h0040_0008);

        // 3: flush in REQ, ack two cycles later
        flush_in_req(0, 1, 32'h0040_0100);
        check("t3_addr_abs", bus.imem_addr, 32'h0040_0100);

        // 4: flush and ack in the same cycle
        flush_with_ack(32'h0040_0200);

        // flush while holding a word
        do_fetch(0, $urandom);
        flush_in_hold(32'h0040_0300);

        // Randomized mix of fetch/stall/flush scenarios
        for (int n = 0; n < 40; n++) begin
            logic [31:0] npc;
            int kind;
            npc  = $urandom & 32'hFFFF_FFFC;
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    do_fetch($urandom_range(0, 6), $urandom);
                    hold_then_advance($urandom_range(0, 3), npc);
                end
                1: flush_in_req($urandom_range(0, 4), $urandom_range(0, 4), npc);
                2: flush_with_ack(npc);
                default: begin
                    do_fetch($urandom_range(0, 6), $urandom);
                    flush_in_hold(npc);
                end
            endcase
        end

        // 6: misaligned next_pc on advance
        do_fetch(1, $urandom);
        stall   = 1'b0;
        next_pc = 32'h0040_0102;
        step();
`ifdef FETCH_MISALIGN_CHECK_EN
        check("t6_mis",   misalign, 1'b1);
        check("t6_err",   fetch_err, 1'b1);
        check("t6_noreq", bus.imem_req, 1'b0);
        check("t6_pc",    pc, 32'h0040_0102);
        step();
        check("t6_noreq2", bus.imem_req, 1'b0);
`else
        check("t6_req",  bus.imem_req, 1'b1);
        check("t6_addr", bus.imem_addr, 32'h0040_0100);
        check("t6_pc",   pc, 32'h0040_0102);
        check("t6_mis",  misalign, 1'b0);
        exp_pc = 32'h0040_0102;
        do_fetch(0, $urandom);
`endif

        // 5: request never acked
        rst_n = 1'b0;
        step();
        rst_n  = 1'b1;
        exp_pc = RESET_PC;
        step();
        expect_req("t5");
        for (int k = 1; k < MAX_WAIT; k++) begin
            step();
            check("t5_still_req", bus.imem_req, 1'b1);
            check("t5_no_err",    fetch_err, 1'b0);
        end
        step();
        check("t5_err",   fetch_err, 1'b1);
        check("t5_noreq", bus.imem_req, 1'b0);
        for (int k = 0; k < 4; k++) begin
            bus.imem_ack = 1'($urandom_range(0, 1));
            step();
            check("t5_err_held",   fetch_err, 1'b1);
            check("t5_noreq_held", bus.imem_req, 1'b0);
            check("t5_valid_low",  instr_valid, 1'b0);
        end
        bus.imem_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("t5_err_cleared", fetch_err, 1'b0);

        // Asynchronous reset pulse while a request is open
        step();
        rst_n = 1'b1;
        step();
        expect_req("t5b");
        #2 rst_n = 1'b0;
        #1 check("t5b_async_req", bus.imem_req, 1'b0);
        check("t5b_async_pc", pc, RESET_PC);
        step();
        rst_n = 1'b1;
        step();
        expect_req("t5b_recover");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
